pci_initiator: RTL and testbench
================================

// Module: pci_initiator
// PURPOSE
//  Bus-master end of the PCI-style bus served by PCI_TARGET. Takes one request (command,
//  address, data-phase count) from local logic and runs the address phase and the
//  data-phase burst. Drives NFRAME/NIRED/C_BE/Address_Data and honours NTRED/NDEVSEL/stop.
//  Handles normal completion, target stop (retry/disconnect/abort) and master abort.
//  Replaces the hand-written initiator stimulus used with PCI_TARGET today.
// PARAMETERS
//  MAX_LEN        16  maximum data phases per request; req_len is $clog2(MAX_LEN+1) bits
//  DEVSEL_TIMEOUT 5   clocks after the address phase to wait for NDEVSEL low before master abort
// PORTS
//  clk          in    1   bus clock; every bus signal is sampled and driven on its rising edge
//  reset        in    1   asynchronous, active-high reset
//  Address_Data inout 32  multiplexed AD bus; high-Z when not driven by this block
//  C_BE         out   4   command (address phase) / byte enables (data phase), active-low; 4'bz when idle
//  NFRAME       out   1   active-low frame
//  NIRED        out   1   active-low initiator ready
//  NTRED        in    1   active-low target ready
//  NDEVSEL      in    1   active-low device select
//  stop         in    1   active-low target stop request
//  req_valid    in    1   start request; accepted only while busy=0
//  req_cmd      in    4   bus command; cmd[0]=1 is write (0111, 0011, 1011), cmd[0]=0 is read
//  req_addr     in    32  start address
//  req_len      in    L   data phases requested, 1..MAX_LEN (0 is treated as 1)
//  wr_data      in    32  current write word; show-ahead, must be valid from req accept
//  wr_be        in    4   active-low byte enables for the current phase (reads and writes)
//  wr_pop       out   1   1-clk pulse: current word consumed, next word due next clock
//  rd_data      out   32  read word captured from Address_Data
//  rd_valid     out   1   1-clk pulse with each completed read data phase
//  busy         out   1   high from req accept until the return to IDLE
//  done         out   1   1-clk pulse on return to IDLE
//  status       out   2   valid with done: 00 ok, 01 master abort, 10 target stop early, 11 target abort
//  xfer_count   out   L   data phases completed in the last request; held until the next accept
// BEHAVIOUR
//  Reset (asynchronous, immediate): NFRAME=1, NIRED=1, Address_Data and C_BE high-Z,
//   busy/done/wr_pop/rd_valid=0, status=00, xfer_count=0, FSM=IDLE. Mid-burst reset abandons the bus.
//  FSM states: IDLE, ADDR, DATA, LAST, TURN.
//  IDLE: accept when req_valid && bus idle (NFRAME and NIRED both sampled high). Latch cmd/addr/len,
//   busy=1, then ADDR.
//  ADDR (1 clk): NFRAME=0, Address_Data=addr, C_BE=cmd. Next state is LAST if len==1, else DATA.
//   Start the devsel counter.
//  DATA/LAST: NIRED=0, C_BE=wr_be. Write drives wr_data; read releases AD (turnaround cycle).
//   NFRAME=1 in LAST (last phase armed) and 0 in DATA.
//  A phase completes on any clock with NIRED=0 && NTRED=0 sampled. On completion:
//   count++, write pulses wr_pop, read pulses rd_valid with rd_data=Address_Data.
//   Move DATA->LAST when count+1==len, so NFRAME rises with the final phase.
//  Wait states (NTRED high) extend the current phase indefinitely; all drives are held.
//  Master abort: NDEVSEL still high after DEVSEL_TIMEOUT clocks -> NFRAME=1 for 1 clk with NIRED=0,
//   then TURN; status=01.
//  stop=0 sampled with NDEVSEL=0: the phase counts only if NTRED=0 too. Go to LAST (NFRAME=1) and
//   hold NIRED=0 until stop is sampled again, then TURN. status=10 if count<len, else 00.
//  stop=0 sampled with NDEVSEL=1 after DEVSEL was seen (target abort): immediate TURN, status=11.
//  Simultaneous final transfer and stop: the transfer counts, status=00.
//  TURN (1 clk): NFRAME=1, NIRED=1, AD/C_BE high-Z. Pulse done, busy=0, then IDLE.
//  Counters are L bits wide and never wrap, because len<=MAX_LEN.
//  req_valid while busy is ignored (no queueing).
// TESTING
//  Write 0111, addr FFFFFFF4, len 5, target zero-wait -> 5 wr_pop; NFRAME high during phase 5;
//   status 00, xfer_count 5.
//  Read 1110, len 3, target one wait state per phase -> 3 rd_valid with target data; AD high-Z
//   from the clock after ADDR.
//  Write len 4 to an unmapped addr (NDEVSEL never low) -> NFRAME high at clock ADDR+5; done with
//   status 01, xfer_count 0.
//  Write len 8, target asserts stop with NTRED low at phase 3 -> xfer_count 3, status 10;
//   the bus released within 2 clocks.
//  Reset pulse in the middle of phase 2 -> NFRAME/NIRED high and AD high-Z in the same timestep;
//   the next request runs normally.
//  Read len 1 (I/O read 0010) -> NFRAME high during the only data phase; 1 rd_valid; status 00.

Source files
------------

// File: rtl/pci_initiator.sv
// Bus-master end of the PCI-style bus. Accepts one request at a time, runs the
// address phase and a burst of data phases. Handles normal completion, target stop,
// target abort and master abort.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | bus released, waiting for req_valid
// ADDR  | address phase: NFRAME low, AD = address, C_BE = command
// DATA  | data phase with more phases to follow (NFRAME low, NIRED low)
// LAST  | final phase armed (NFRAME high, NIRED low); also stop-hold and master-abort clock
// TURN  | turnaround: everything released, done pulsed
module pci_initiator #(
    parameter int MAX_LEN        = 16,
    parameter int DEVSEL_TIMEOUT = 5,
    localparam int L             = $clog2(MAX_LEN + 1)
) (
    input  logic         clk,
    input  logic         reset,
    inout  wire  [31:0]  Address_Data,
    output logic [3:0]   C_BE,
    output logic         NFRAME,
    output logic         NIRED,
    input  logic         NTRED,
    input  logic         NDEVSEL,
    input  logic         stop,
    input  logic         req_valid,
    input  logic [3:0]   req_cmd,
    input  logic [31:0]  req_addr,
    input  logic [L-1:0] req_len,
    input  logic [31:0]  wr_data,
    input  logic [3:0]   wr_be,
    output logic         wr_pop,
    output logic [31:0]  rd_data,
    output logic         rd_valid,
    output logic         busy,
    output logic         done,
    output logic [1:0]   status,
    output logic [L-1:0] xfer_count
);

    localparam int DW = $clog2(DEVSEL_TIMEOUT + 1);

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_MABORT = 2'b01;
    localparam logic [1:0] ST_EARLY  = 2'b10;
    localparam logic [1:0] ST_TABORT = 2'b11;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, LAST, TURN} state_t;

    state_t        state, next_state;
    logic [3:0]    cmd_q;
    logic [31:0]   addr_q;
    logic [L-1:0]  len_q;
    logic [DW-1:0] devsel_cnt;
    logic          devsel_seen;
    logic          abort_q;
    logic          hold_q;

    logic          ad_oe, cbe_oe;
    logic [31:0]   ad_out;
    logic [3:0]    cbe_out;
    logic          accept, xfer, go_abort, go_stop, go_tabort;
    logic [L-1:0]  count_inc, count_new;
    logic          in_data;

    assign count_inc    = xfer_count + L'(1);
    assign count_new    = xfer ? count_inc : xfer_count;
    assign in_data      = (state == DATA) || (state == LAST);
    assign busy         = (state != IDLE);
    assign Address_Data = ad_oe ? ad_out : 'z;
    assign C_BE         = cbe_oe ? cbe_out : 'z;

    // State register; reset abandons the bus immediately since all drives decode from state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state, bus drives and per-clock phase decisions.
    always_comb begin
        next_state = state;
        NFRAME     = 1'b1;
        NIRED      = 1'b1;
        ad_oe      = 1'b0;
        ad_out     = wr_data;
        cbe_oe     = 1'b0;
        cbe_out    = wr_be;
        accept     = 1'b0;
        xfer       = 1'b0;
        go_abort   = 1'b0;
        go_stop    = 1'b0;
        go_tabort  = 1'b0;
        case (state)
            IDLE: begin
                // Our own NFRAME/NIRED are both high here, so the bus is idle by construction.
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = ADDR;
                end
            end
            ADDR: begin
                NFRAME     = 1'b0;
                ad_oe      = 1'b1;
                ad_out     = addr_q;
                cbe_oe     = 1'b1;
                cbe_out    = cmd_q;
                next_state = (len_q == L'(1)) ? LAST : DATA;
            end
            DATA, LAST: begin
                NFRAME = (state == LAST);
                NIRED  = 1'b0;
                cbe_oe = 1'b1;
                ad_oe  = cmd_q[0];
                if (abort_q) begin
                    next_state = TURN;
                end else if (hold_q) begin
                    if (stop) next_state = TURN;
                end else if (!stop && !NDEVSEL) begin
                    xfer       = !NTRED;
                    go_stop    = 1'b1;
                    next_state = LAST;
                end else if (!stop && NDEVSEL && devsel_seen) begin
                    go_tabort  = 1'b1;
                    next_state = TURN;
                end else if (NDEVSEL && !devsel_seen && devsel_cnt == DW'(1)) begin
                    go_abort   = 1'b1;
                    next_state = LAST;
                end else if (!NTRED) begin
                    xfer = 1'b1;
                    if (state == LAST)                        next_state = TURN;
                    else if ((count_inc + L'(1)) == len_q)    next_state = LAST;
                end
            end
            TURN: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        wr_pop = xfer && cmd_q[0];
    end

    // Request latch, devsel timer, phase counter, read capture and completion status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q       <= '0;
            addr_q      <= '0;
            len_q       <= L'(1);
            devsel_cnt  <= '0;
            devsel_seen <= 1'b0;
            abort_q     <= 1'b0;
            hold_q      <= 1'b0;
            xfer_count  <= '0;
            status      <= ST_OK;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            done        <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            if (accept) begin
                cmd_q       <= req_cmd;
                addr_q      <= req_addr;
                len_q       <= (req_len == '0) ? L'(1) : req_len;
                xfer_count  <= '0;
                status      <= ST_OK;
                devsel_seen <= 1'b0;
                abort_q     <= 1'b0;
                hold_q      <= 1'b0;
            end
            if (state == ADDR)
                devsel_cnt <= DW'(DEVSEL_TIMEOUT - 1);
            else if (in_data && NDEVSEL && !devsel_seen && devsel_cnt != '0)
                devsel_cnt <= devsel_cnt - DW'(1);
            if (in_data && !NDEVSEL)
                devsel_seen <= 1'b1;
            if (xfer) begin
                xfer_count <= count_inc;
                if (!cmd_q[0]) begin
                    rd_valid <= 1'b1;
                    rd_data  <= Address_Data;
                end
            end
            if (go_abort) begin
                abort_q <= 1'b1;
                status  <= ST_MABORT;
            end
            if (go_stop) begin
                hold_q <= 1'b1;
                status <= (count_new < len_q) ? ST_EARLY : ST_OK;
            end
            if (go_tabort)
                status <= ST_TABORT;
            if (state == TURN)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pci_initiator.sv
// Bench for pci_initiator: a behavioural target answers each request, a
// transaction-level model predicts status, count and data words.
module tb_pci_initiator;

    localparam int DEVSEL_TIMEOUT = 5;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        int          len;
        int          waits;
        bit          devsel;
        int          mode;    // 0 none, 1 stop with NTRED at phase sph, 2 target abort in phase sph
        int          sph;
        logic [3:0]  be;
        logic [1:0]  exp_st;
        int          exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    wire  [31:0] ad;
    logic        tb_ad_oe = 1'b0;
    logic [31:0] tb_ad = '0;
    wire  [3:0]  c_be;
    logic        nframe, nired;
    logic        ntred = 1'b1, ndevsel = 1'b1, stop_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_cmd = '0;
    logic [31:0] req_addr = '0;
    logic [4:0]  req_len = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        wr_pop, rd_valid, busy, done;
    logic [31:0] rd_data;
    logic [1:0]  status;
    logic [4:0]  xfer_count;

    int n_cmp = 0;
    int n_err = 0;

    assign ad = tb_ad_oe ? tb_ad : 'z;

    always #5 clk = ~clk;

    pci_initiator #(.MAX_LEN(16), .DEVSEL_TIMEOUT(DEVSEL_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .Address_Data(ad), .C_BE(c_be),
        .NFRAME(nframe), .NIRED(nired), .NTRED(ntred), .NDEVSEL(ndevsel), .stop(stop_n),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_be(wr_be), .wr_pop(wr_pop), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .status(status), .xfer_count(xfer_count)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Transaction-level outcome from the bus rules.
    function automatic void model(input vec_t v, output logic [1:0] st, output int cnt);
        int le;
        le = (v.len == 0) ? 1 : v.len;
        if (!v.devsel) begin
            st = 2'b01; cnt = 0;
        end else if (v.mode == 1 && v.sph <= le) begin
            cnt = v.sph; st = (cnt < le) ? 2'b10 : 2'b00;
        end else if (v.mode == 2 && v.sph <= le) begin
            cnt = v.sph - 1; st = 2'b11;
        end else begin
            cnt = le; st = 2'b00;
        end
    endfunction

    task automatic run_txn(input vec_t v, input logic [1:0] exp_st, input int exp_cnt, input string tag);
        int le, c, p, pc, pops, frame_hi, stop_cyc, rel_cyc, frame_err, ad_err, data_err, idx;
        bit is_wr, active, seen_done, prev_pop, complete, probe;
        logic [1:0]  got_st;
        logic [4:0]  got_cnt;
        logic        got_busy;
        logic [31:0] words [0:16];
        logic [31:0] got_q [$];
        le = (v.len == 0) ? 1 : v.len;
        is_wr = v.cmd[0];
        for (int i = 0; i <= 16; i++) words[i] = $urandom | 32'h1;
        @(negedge clk);
        req_valid = 1'b1; req_cmd = v.cmd; req_addr = v.addr; req_len = 5'(v.len);
        idx = 0; wr_data = words[0]; wr_be = v.be;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ":addr_phase"}, {nframe, nired, busy, c_be, ad}, {1'b0, 1'b1, 1'b1, v.cmd, v.addr});
        ndevsel = v.devsel ? 1'b0 : 1'b1;
        active = v.devsel;
        c = 0; p = 0; pc = 0; pops = 0; frame_hi = -1; stop_cyc = -1; rel_cyc = -1;
        frame_err = 0; ad_err = 0; seen_done = 0; prev_pop = 0;
        got_st = '0; got_cnt = '0; got_busy = 1'b1;
        while (!seen_done && c < 400) begin
            @(negedge clk);
            c++;
            complete = 0; probe = 0;
            if (rd_valid) got_q.push_back(rd_data);
            if (done) begin
                seen_done = 1; got_st = status; got_cnt = xfer_count; got_busy = busy;
            end
            if (prev_pop) begin
                pops++;
                if (idx < 16) idx++;
                wr_data = words[idx];
            end
            if (nframe && frame_hi < 0) frame_hi = c;
            if (stop_cyc >= 0 && nired && rel_cyc < 0) rel_cyc = c;
            ntred = 1'b1; stop_n = 1'b1; tb_ad_oe = 1'b0;
            if (active && !nired) begin
                if (v.mode == 2 && p + 1 == v.sph) begin
                    if (pc >= 1) begin
                        ndevsel = 1'b1; stop_n = 1'b0; active = 0;
                    end else pc++;
                end else if (pc >= v.waits) begin
                    ntred = 1'b0; complete = 1;
                    if (!is_wr) begin tb_ad_oe = 1'b1; tb_ad = words[p]; end
                    if (nframe !== (p == le - 1) || c_be !== v.be) frame_err++;
                    if (v.mode == 1 && p + 1 == v.sph) begin
                        stop_n = 1'b0; active = 0; stop_cyc = c;
                    end
                    p++; pc = 0;
                end else pc++;
            end
            if (!is_wr && !tb_ad_oe) begin tb_ad_oe = 1'b1; tb_ad = '0; probe = 1; end
            #1;
            prev_pop = wr_pop;
            if (complete && is_wr) got_q.push_back(ad);
            if (probe && ad !== 32'h0) ad_err++;
        end
        tb_ad_oe = 1'b0; ndevsel = 1'b1; ntred = 1'b1; stop_n = 1'b1;
        data_err = 0;
        for (int i = 0; i < got_q.size(); i++)
            if (i >= exp_cnt || got_q[i] !== words[i]) data_err++;
        chk({tag, ":done_seen"}, seen_done, 1);
        chk({tag, ":status"}, got_st, exp_st);
        chk({tag, ":xfer_count"}, got_cnt, exp_cnt);
        chk({tag, ":busy_at_done"}, got_busy, 0);
        chk({tag, ":pulses"}, is_wr ? pops : got_q.size(), exp_cnt);
        chk({tag, ":data"}, data_err, 0);
        chk({tag, ":phase_ctl"}, frame_err, 0);
        if (!is_wr) chk({tag, ":ad_release"}, ad_err, 0);
        if (!v.devsel) chk({tag, ":abort_time"}, frame_hi, (le == 1) ? 1 : DEVSEL_TIMEOUT);
        if (stop_cyc >= 0) chk({tag, ":bus_release"}, (rel_cyc >= 0 && rel_cyc - stop_cyc <= 2), 1);
    endtask

    initial begin
        vec_t tbl [10];
        vec_t v;
        logic [3:0] cmds [6];
        logic [1:0] st;
        int cnt, le;

        tbl[0] = '{4'b0111, 32'hFFFF_FFF4, 5,  0, 1'b1, 0, 0, 4'h0, 2'b00, 5};
        tbl[1] = '{4'b1110, 32'h0000_1000, 3,  1, 1'b1, 0, 0, 4'h0, 2'b00, 3};
        tbl[2] = '{4'b0111, 32'h4000_0000, 4,  0, 1'b0, 0, 0, 4'h0, 2'b01, 0};
        tbl[3] = '{4'b0111, 32'h0000_2000, 8,  0, 1'b1, 1, 3, 4'h5, 2'b10, 3};
        tbl[4] = '{4'b0010, 32'h0000_03F8, 1,  0, 1'b1, 0, 0, 4'hE, 2'b00, 1};
        tbl[5] = '{4'b0011, 32'h0000_3000, 2,  0, 1'b1, 1, 2, 4'h0, 2'b00, 2};
        tbl[6] = '{4'b0110, 32'h0000_4000, 6,  0, 1'b1, 2, 4, 4'h0, 2'b11, 3};
        tbl[7] = '{4'b1011, 32'h0000_5000, 0,  0, 1'b1, 0, 0, 4'hC, 2'b00, 1};
        tbl[8] = '{4'b1110, 32'h0000_6000, 16, 2, 1'b1, 0, 0, 4'h0, 2'b00, 16};
        tbl[9] = '{4'b0110, 32'h8000_0000, 1,  0, 1'b0, 0, 0, 4'h0, 2'b01, 0};
        cmds = '{4'b0111, 4'b0011, 4'b1011, 4'b0110, 4'b1110, 4'b0010};

        tb_ad_oe = 1'b1; tb_ad = '0;
        repeat (3) @(negedge clk);
        chk("reset:frame_ired", {nframe, nired}, 2'b11);
        chk("reset:busy_done", {busy, done}, 2'b00);
        chk("reset:pulses", {wr_pop, rd_valid}, 2'b00);
        chk("reset:status_count", {status, xfer_count}, 7'd0);
        chk("reset:ad_release", ad, 32'h0);
        reset = 1'b0; tb_ad_oe = 1'b0;

        for (int i = 0; i < 10; i++)
            run_txn(tbl[i], tbl[i].exp_st, tbl[i].exp_cnt, $sformatf("vec%0d", i));

        // Reset in the middle of data phase 2 of a write burst.
        v = '{4'b0111, 32'h1234_5670, 4, 0, 1'b1, 0, 0, 4'h3, 2'b00, 4};
        @(negedge clk);
        req_valid = 1'b1; req_cmd = v.cmd; req_addr = v.addr; req_len = 5'd4;
        wr_data = 32'hA5A5_0001; wr_be = v.be;
        @(negedge clk);
        req_valid = 1'b0; ndevsel = 1'b0;
        @(negedge clk);
        ntred = 1'b0;
        @(negedge clk);
        wr_data = 32'hA5A5_0002; ntred = 1'b1;
        #1 chk("rst_mid:pre", {nframe, nired, ad}, {2'b00, 32'hA5A5_0002});
        #1 tb_ad_oe = 1'b1; tb_ad = '0; reset = 1'b1;
        #1 chk("rst_mid:bus", {nframe, nired, busy, wr_pop, ad}, {4'b1100, 32'h0});
        #1 reset = 1'b0; tb_ad_oe = 1'b0; ndevsel = 1'b1;
        run_txn(v, 2'b00, 4, "after_rst");

        for (int i = 0; i < 25; i++) begin
            v.cmd    = cmds[$urandom_range(0, 5)];
            v.addr   = $urandom;
            v.len    = $urandom_range(0, 16);
            le       = (v.len == 0) ? 1 : v.len;
            v.waits  = $urandom_range(0, 2);
            v.devsel = ($urandom_range(0, 9) != 0);
            v.mode   = $urandom_range(0, 2);
            v.sph    = $urandom_range(1, le);
            v.be     = 4'($urandom);
            model(v, st, cnt);
            run_txn(v, st, cnt, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
